demux_handshake_module: RTL
===========================

DEMUX_HANDSHAKE_MODULE -- requirements
Module: demux_handshake_module

Interface
REQ-001 SHALL have parameter WIDTH_IN, default 2, meaning select width in bits.
REQ-002 SHALL have parameter WIDTH_OP, default 4, meaning number of output channels (1..2^WIDTH_IN).
REQ-003 SHALL have parameter WIDTH_BUS, default 3, meaning data bus width in bits.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  producer offers a word.
REQ-007 SHALL have port in_ready  output  1  block accepts the offered word this cycle.
REQ-008 SHALL have port sel  input  WIDTH_IN  destination channel index for the offered word.
REQ-009 SHALL have port in  input  WIDTH_BUS  data word.
REQ-010 SHALL have port out  output  [WIDTH_OP-1:0][WIDTH_BUS-1:0]  per-channel registered data.
REQ-011 SHALL have port out_valid  output  WIDTH_OP  per-channel data-present flag.
REQ-012 SHALL have port out_ready  input  WIDTH_OP  per-channel consumer accept.
REQ-013 SHALL have port err  output  1  one-cycle pulse on an accepted word with out-of-range sel.

Function
REQ-014 SHALL hold one registered entry per channel: out[k] plus out_valid[k].
REQ-015 SHALL drive in_ready combinationally: 1 if sel >= WIDTH_OP, else (!out_valid[sel] || out_ready[sel]).
REQ-016 SHALL define transfer in as in_valid && in_ready; channel drain k as out_valid[k] && out_ready[k].
REQ-017 SHALL, on transfer with sel < WIDTH_OP, load out[sel] <= in and set out_valid[sel] = 1 at the next edge (latency 1 cycle).
REQ-018 SHALL, on drain of k with no simultaneous load to k, clear out_valid[k] at the next edge; out[k] keeps its last value.
REQ-019 SHALL, on simultaneous drain and load to the same channel, keep out_valid = 1 and present the new word next cycle (no bubble, no loss).
REQ-020 SHALL keep out[k] stable while out_valid[k] && !out_ready[k].
REQ-021 SHALL leave all channels other than sel unchanged by a transfer; drains on different channels proceed independently in the same cycle.
REQ-022 SHALL, on transfer with sel >= WIDTH_OP, drop the word, change no channel, and assert err for exactly the next cycle.
REQ-023 SHALL keep err low in every cycle not following such a drop; back-to-back drops give err high on consecutive cycles.
REQ-024 SHALL ignore sel and in when in_valid = 0.

Reset
REQ-025 SHALL, while rst_n = 0, force out_valid = 0, every out[k] = 0, err = 0, independent of clk.
REQ-026 SHALL discard any pending entries on reset mid-operation; first transfer after release behaves as from empty.
REQ-027 SHALL drive in_ready per REQ-015 during reset (all channels empty, so in_ready = 1), but SHALL not capture any word until rst_n = 1.

Configuration
REQ-028 SHALL, with macro DEMUX_DROP_CNT_EN defined, add output drop_cnt [7:0]: reset to 0, +1 on each out-of-range drop, saturating at 255.
REQ-029 SHALL, without DEMUX_DROP_CNT_EN, omit drop_cnt entirely with all other behaviour identical.

Verification (defaults unless stated; out_ready = all ones unless stated)
REQ-030 SHALL cover: sel = 0,1,2,3 with in = 3'b110,3'b100,3'b101,3'b011 on consecutive cycles -> each out[sel] holds its word with out_valid[sel] one cycle after transfer, other channels untouched.
REQ-031 SHALL cover: out_ready[2] = 0, send in = 3'b101 to sel = 2, then in = 3'b011 to sel = 2 -> second offer sees in_ready = 0 and out[2] stays 3'b101; raise out_ready[2] -> second word accepted same cycle, out[2] = 3'b011 next cycle, out_valid[2] never drops.
REQ-032 SHALL cover: out_ready[1] = 0 with channel 1 full, send to sel = 3 -> accepted immediately, out[3] updated, channel 1 unchanged.
REQ-033 SHALL cover: WIDTH_OP = 3, send sel = 3, in = 3'b111 twice -> in_ready = 1, no out_valid change, err high two consecutive cycles, drop_cnt = 2 when DEMUX_DROP_CNT_EN defined.
REQ-034 SHALL cover: load channels 0 and 2 with out_ready = 0, assert rst_n = 0 between clock edges -> out_valid = 0 and out = 0 immediately; after release, sel = 0, in = 3'b001 -> out[0] = 3'b001 one cycle later.

Source files
------------

// File: rtl/demux_handshake_module.sv
// demux_handshake_module: valid/ready 1-to-N demux, one register slot per channel.
// Optional DEMUX_DROP_CNT_EN adds drop_cnt, a saturating out-of-range drop counter.
module demux_handshake_module #(
  parameter int WIDTH_IN  = 2,
  parameter int WIDTH_OP  = 4,
  parameter int WIDTH_BUS = 3
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [WIDTH_IN-1:0]                 sel,
  input  logic [WIDTH_BUS-1:0]                in,
  output logic [WIDTH_OP-1:0][WIDTH_BUS-1:0]  out,
  output logic [WIDTH_OP-1:0]                 out_valid,
  input  logic [WIDTH_OP-1:0]                 out_ready,
`ifdef DEMUX_DROP_CNT_EN
  output logic [7:0]                          drop_cnt,
`endif
  output logic                                err
);

  logic [WIDTH_OP-1:0][WIDTH_BUS-1:0] data_q, data_d;
  logic [WIDTH_OP-1:0]                vld_q, vld_d;
  logic                               err_q, err_d;

  logic [31:0]         sel_ext;
  logic                sel_ok;
  logic [WIDTH_OP-1:0] hit;
  logic [WIDTH_OP-1:0] load;
  logic [WIDTH_OP-1:0] drain;
  logic                xfer;

  assign sel_ext = 32'(sel);
  assign sel_ok  = sel_ext < 32'(WIDTH_OP);
  assign xfer    = in_valid && in_ready;

  // Decode sel to a one-hot channel hit; out-of-range sel hits nothing.
  always_comb begin
    hit = '0;
    for (int k = 0; k < WIDTH_OP; k++) begin
      hit[k] = sel_ok && (sel_ext == 32'(k));
    end
  end

  // Ready when the target slot is empty or draining; dropped words always accepted.
  always_comb begin
    in_ready = 1'b1;
    for (int k = 0; k < WIDTH_OP; k++) begin
      if (hit[k]) begin
        in_ready = !vld_q[k] || out_ready[k];
      end
    end
  end

  // Per-channel next state: a load wins over a drain so no bubble appears.
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    load   = '0;
    drain  = '0;
    for (int k = 0; k < WIDTH_OP; k++) begin
      load[k]  = xfer && hit[k];
      drain[k] = vld_q[k] && out_ready[k];
      vld_d[k] = load[k] || (vld_q[k] && !drain[k]);
      if (load[k]) begin
        data_d[k] = in;
      end
    end
    err_d = xfer && !sel_ok;
  end

  // Channel slots and the drop pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      vld_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
      err_q  <= err_d;
    end
  end

`ifdef DEMUX_DROP_CNT_EN
  logic [7:0] cnt_q, cnt_d;

  // Count dropped words, holding at 255.
  always_comb begin
    cnt_d = cnt_q;
    if (err_d && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign drop_cnt = cnt_q;
`endif

  assign out       = data_q;
  assign out_valid = vld_q;
  assign err       = err_q;

endmodule
